// File: rtl/cdc_xfer_pkg.sv
// Shared definitions for the CDC transfer arbiter.
// - state_e : arbiter FSM encoding (IDLE=0, LOAD=1, REQ_HI=2, REQ_LO=3)
// - clog2_f : constant-foldable ceil(log2(n)), used for parameter checks
package cdc_xfer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StReqHi = 2'd2,
    StReqLo = 2'd3
  } state_e;

  function automatic int unsigned clog2_f(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/cdc_xfer_arb_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i   : request vector
//   ptr_i   : highest-priority index this round
//   valid_o : any request present
//   idx_o   : first set request at or after ptr_i, wrapping modulo N_REQ
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned SW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [SW-1:0]    ptr_i,
  output logic             valid_o,
  output logic [SW-1:0]    idx_o
);

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % int'(N_REQ)]) begin
        valid_o = 1'b1;
        idx_o   = SW'((int'(ptr_i) + k) % int'(N_REQ));
      end
    end
  end

endmodule

// File: rtl/reg_tech_cdc.sv
// Single-bit level synchronizer, POST_STAGES+1 flops deep.
// Ports:
//   clk_i : destination clock
//   d_i   : asynchronous input level
//   q_o   : synchronized level
// The chain has no reset on purpose: a far-side level that is still high
// when the launching domain resets must stay visible so it can be drained.
module reg_tech_cdc #(
  parameter int unsigned POST_STAGES = 1
) (
  input  logic clk_i,
  input  logic d_i,
  output logic q_o
);

  logic [POST_STAGES:0] sync_q;

  always_ff @(posedge clk_i) begin
    sync_q[0] <= d_i;
    for (int i = 1; i <= int'(POST_STAGES); i++) begin
      sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[POST_STAGES];

endmodule

// File: rtl/cdc_xfer_arb.sv
// Shares one four-phase req/ack CDC channel among N_REQ local requesters.
// Round-robin picks a requester, captures its word, raises xfer_req, waits
// for the synchronized far-side ack (or a timeout), then completes the
// return-to-zero phase before the next grant.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   req, req_data     : level requests and packed per-requester words
//   done              : one-cycle pulse to the acknowledged requester
//   timeout           : one-cycle pulse when the ack wait expires
//   busy              : FSM not in IDLE
//   xfer_data/src/req : held word, owner index and request to far domain
//   ack_async         : far-domain acknowledge
module cdc_xfer_arb
  import cdc_xfer_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DW          = 16,
  parameter int unsigned SW          = 2,
  parameter int unsigned POST_STAGES = 1,
  parameter int unsigned TO_W        = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    done,
  output logic                timeout,
  output logic                busy,
  output logic [DW-1:0]       xfer_data,
  output logic [SW-1:0]       xfer_src,
  output logic                xfer_req,
  input  logic                ack_async
);

  if (SW < clog2_f(N_REQ)) begin : gen_sw_check
    $error("cdc_xfer_arb: SW too narrow for N_REQ");
  end
  if (N_REQ < 2 || N_REQ > 8) begin : gen_nreq_check
    $error("cdc_xfer_arb: N_REQ out of range 2..8");
  end

  // Last count value before expiry: keeps xfer_req high 2^TO_W-1 cycles.
  localparam logic [TO_W-1:0] CntLast = {{(TO_W-1){1'b1}}, 1'b0};

  state_e            state_q, state_d;
  logic [SW-1:0]     rr_q, rr_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  logic              xfer_req_q, xfer_req_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic              timeout_q, timeout_d;
  logic              busy_q, busy_d;
  logic [DW-1:0]     xfer_data_q, xfer_data_d;
  logic [SW-1:0]     xfer_src_q, xfer_src_d;

  logic              ack_s;
  logic              pick_valid;
  logic [SW-1:0]     pick_idx;
  logic [DW-1:0]     pick_word;
  logic              grant;
  logic [SW-1:0]     rr_next;

  reg_tech_cdc #(
    .POST_STAGES (POST_STAGES)
  ) u_ack_sync (
    .clk_i (clk),
    .d_i   (ack_async),
    .q_o   (ack_s)
  );

  rr_pick #(
    .N_REQ (N_REQ),
    .SW    (SW)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (rr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign pick_word = req_data[int'(pick_idx) * DW +: DW];
  // A still-high ack means an earlier transfer has not drained; hold off.
  assign grant     = (state_q == StIdle) && !ack_s && pick_valid;
  assign rr_next   = (xfer_src_q == SW'(N_REQ - 1)) ? '0 : xfer_src_q + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant) state_d = StLoad;
      StLoad:  state_d = StReqHi;
      StReqHi: if (ack_s || cnt_q == CntLast) state_d = StReqLo;
      StReqLo: if (!ack_s) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    xfer_req_d  = xfer_req_q;
    done_d      = '0;
    timeout_d   = 1'b0;
    xfer_data_d = xfer_data_q;
    xfer_src_d  = xfer_src_q;
    busy_d      = (state_d != StIdle);
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          xfer_data_d = pick_word;
          xfer_src_d  = pick_idx;
        end
      end
      StLoad: begin
        xfer_req_d = 1'b1;
        cnt_d      = '0;
      end
      StReqHi: begin
        cnt_d = cnt_q + 1'b1;
        // Ack takes priority over a coincident expiry.
        if (ack_s) begin
          xfer_req_d         = 1'b0;
          done_d[xfer_src_q] = 1'b1;
          rr_d               = rr_next;
        end else if (cnt_q == CntLast) begin
          xfer_req_d = 1'b0;
          timeout_d  = 1'b1;
          rr_d       = rr_next;
        end
      end
      StReqLo: begin
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q        <= '0;
      cnt_q       <= '0;
      xfer_req_q  <= 1'b0;
      done_q      <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      xfer_data_q <= '0;
      xfer_src_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      xfer_req_q  <= xfer_req_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      busy_q      <= busy_d;
      xfer_data_q <= xfer_data_d;
      xfer_src_q  <= xfer_src_d;
    end
  end

  assign done      = done_q;
  assign timeout   = timeout_q;
  assign busy      = busy_q;
  assign xfer_data = xfer_data_q;
  assign xfer_src  = xfer_src_q;
  assign xfer_req  = xfer_req_q;

endmodule

// File: tb/tb_cdc_xfer_arb.sv
module tb_cdc_xfer_arb;

  localparam int unsigned N_REQ       = 4;
  localparam int unsigned DW          = 16;
  localparam int unsigned SW          = 2;
  localparam int unsigned POST_STAGES = 1;
  localparam int unsigned TO_W        = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    done;
  logic                timeout;
  logic                busy;
  logic [DW-1:0]       xfer_data;
  logic [SW-1:0]       xfer_src;
  logic                xfer_req;
  logic                ack_model;
  logic                ack_force;
  logic                ack_en;
  logic                ack_async;

  assign ack_async = ack_model | ack_force;

  always #5 clk = ~clk;

  cdc_xfer_arb #(
    .N_REQ       (N_REQ),
    .DW          (DW),
    .SW          (SW),
    .POST_STAGES (POST_STAGES),
    .TO_W        (TO_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .done      (done),
    .timeout   (timeout),
    .busy      (busy),
    .xfer_data (xfer_data),
    .xfer_src  (xfer_src),
    .xfer_req  (xfer_req),
    .ack_async (ack_async)
  );

  typedef struct {
    int          src;
    logic [15:0] data;
    bit          to;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push(input int src, input logic [15:0] data, input bit to);
    exp_t e;
    e.src  = src;
    e.data = data;
    e.to   = to;
    exp_q.push_back(e);
  endtask

  // Far-domain model: ack 3 cycles after xfer_req rises, release 3 cycles
  // after it falls. Offset #2 keeps it off the stimulus sampling point.
  initial begin
    ack_model = 1'b0;
    forever begin
      wait (xfer_req == 1'b1);
      if (ack_en) begin
        repeat (3) @(posedge clk);
        #2 ack_model = 1'b1;
        wait (xfer_req == 1'b0);
        repeat (3) @(posedge clk);
        #2 ack_model = 1'b0;
      end else begin
        wait (xfer_req == 1'b0);
      end
    end
  end

  // Monitor / scoreboard
  logic        prev_req  = 1'b0;
  logic [3:0]  prev_done = '0;
  logic        prev_to   = 1'b0;
  int          hi_cnt    = 0;
  logic [15:0] held      = '0;

  always @(negedge clk) begin
    exp_t e;
    if (xfer_req && !prev_req) begin
      hi_cnt = 0;
      held   = xfer_data;
      if (exp_q.size() == 0) begin
        check("unexpected xfer_req", 64'(xfer_req), 64'd0);
      end else begin
        check("grant src", 64'(xfer_src), 64'(exp_q[0].src));
        check("grant data", 64'(xfer_data), 64'(exp_q[0].data));
      end
    end
    if (xfer_req) begin
      hi_cnt++;
      check("data stable", 64'(xfer_data), 64'(held));
    end
    if (prev_done != 0) check("done width", 64'(done), 64'd0);
    if (prev_to) check("timeout width", 64'(timeout), 64'd0);
    if (done != 0 || timeout) begin
      if (exp_q.size() == 0) begin
        check("unexpected completion", {59'd0, timeout, done}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("done vec", 64'(done), e.to ? 64'd0 : 64'(1 << e.src));
        check("timeout flag", 64'(timeout), 64'(e.to));
        if (timeout) check("timeout req cycles", 64'(hi_cnt), 64'd15);
      end
    end
    prev_req  = xfer_req;
    prev_done = done;
    prev_to   = timeout;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // what: 0 idle, 1 xfer_req, 2 ack_async, 3 timeout, 10+i done[i]
  function automatic bit probe(input int what);
    case (what)
      0:       return !busy;
      1:       return xfer_req;
      2:       return ack_async;
      3:       return timeout;
      default: return done[what-10];
    endcase
  endfunction

  task automatic wait_until(input int what, input int max, output int cycles);
    cycles = 0;
    while (cycles < max && !probe(what)) begin
      tick();
      cycles++;
    end
    if (!probe(what)) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait %0d: timed out after %0d cycles", what, max);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " xfer_req"}, 64'(xfer_req), 64'd0);
    check({tag, " done"}, 64'(done), 64'd0);
    check({tag, " timeout"}, 64'(timeout), 64'd0);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " xfer_data"}, 64'(xfer_data), 64'd0);
    check({tag, " xfer_src"}, 64'(xfer_src), 64'd0);
  endtask

  task automatic set_word(input int i, input logic [15:0] w);
    req_data[i*DW +: DW] = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    rst_n     = 1'b0;
    req       = '0;
    req_data  = '0;
    ack_force = 1'b0;
    ack_en    = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // 1: single requester, latency and capture before request
    set_word(1, 16'hBEEF);
    push(1, 16'hBEEF, 1'b0);
    req = 4'b0010;
    tick();
    check("t1 busy", 64'(busy), 64'd1);
    check("t1 data at load", 64'(xfer_data), 64'hBEEF);
    check("t1 src at load", 64'(xfer_src), 64'd1);
    check("t1 req low at load", 64'(xfer_req), 64'd0);
    wait_until(11, 40, c);
    check("t1 latency", 64'(c + 1), 64'd8);
    req = '0;
    wait_until(0, 40, c);
    check("t1 idle", 64'(busy), 64'd0);

    // reset to bring the round-robin pointer back to 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_outputs("reset2");

    // 2: all requesting, order 0,1,2,3,0
    for (int i = 0; i < 4; i++) set_word(i, 16'hA000 + 16'(i));
    for (int i = 0; i < 5; i++) push(i % 4, 16'hA000 + 16'(i % 4), 1'b0);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) wait_until(10 + (i % 4), 60, c);
    req = '0;
    wait_until(0, 40, c);

    // 3: no ack -> timeout on 2, then rr moves on to 0, then 2
    ack_en = 1'b0;
    set_word(0, 16'h3000);
    set_word(2, 16'h3002);
    push(2, 16'h3002, 1'b1);
    push(0, 16'h3000, 1'b0);
    push(2, 16'h3002, 1'b0);
    req = 4'b0101;
    wait_until(3, 60, c);
    check("t3 no done on timeout", 64'(done), 64'd0);
    ack_en = 1'b1;
    wait_until(10, 60, c);
    req[0] = 1'b0;
    wait_until(12, 60, c);
    req[2] = 1'b0;
    wait_until(0, 40, c);

    // 4: stale ack held high blocks the grant
    ack_force = 1'b1;
    repeat (3) tick();
    set_word(3, 16'h4444);
    push(3, 16'h4444, 1'b0);
    req = 4'b1000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4 held off", 64'(busy), 64'd0);
    end
    ack_force = 1'b0;
    wait_until(13, 40, c);
    req = '0;
    wait_until(0, 40, c);

    // 5: reset during REQ_HI, then drain the stale ack
    set_word(0, 16'h5555);
    push(0, 16'h5555, 1'b0);
    req = 4'b0001;
    wait_until(1, 20, c);
    wait_until(2, 20, c);
    tick();
    exp_q.delete();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_reset_outputs("t5 reset");
    push(0, 16'h5555, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5 no grant while ack_s", 64'(busy), 64'd0);
    end
    wait_until(10, 40, c);
    req = '0;
    wait_until(0, 40, c);

    // 6: requester drops req after capture
    set_word(2, 16'hC0DE);
    push(2, 16'hC0DE, 1'b0);
    req = 4'b0100;
    wait_until(1, 20, c);
    req = '0;
    set_word(2, 16'hDEAD);
    wait_until(12, 40, c);
    wait_until(0, 40, c);
    repeat (4) tick();
    check("t6 stays idle", 64'(busy), 64'd0);
    check("queue drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
